// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the sequential carry-lookahead adder controller.
//   - ST_IDLE / ST_RUN / ST_DONE : state encodings used by the controller FSM
//   - NIBBLE                     : width of one carry-lookahead slice pass
//   - state_e                    : controller state type built on the encodings
//   - clog2()                    : ceiling log2, sizes the nibble index counter
// ---------------------------------------------------------------------------
package cla_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int NIBBLE = 4;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_e;

   // Ceiling log2; returns at least 1 so a counter is never zero bits wide
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      if (result == 0) begin
         result = 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/cla_4bit.sv
// ---------------------------------------------------------------------------
// cla_4bit
// Combinational 4-bit carry-lookahead adder slice.
//   a_i, b_i : 4-bit addends
//   c_i      : carry-in
//   sum_o    : 4-bit sum
//   cout_o   : carry-out of bit 3
//   g_o, p_o : group generate / propagate for cascading into a wider tree
// ---------------------------------------------------------------------------
module cla_4bit (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       c_i,
   output logic [3:0] sum_o,
   output logic       cout_o,
   output logic       g_o,
   output logic       p_o
);

   logic [3:0] gen;
   logic [3:0] prop;
   logic [4:0] carry;

   // Every carry is expanded directly from generate/propagate terms so no
   // carry ripples through more than two gate levels.
   always_comb begin
      gen      = a_i & b_i;
      prop     = a_i ^ b_i;
      carry[0] = c_i;
      carry[1] = gen[0] | (prop[0] & c_i);
      carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & c_i);
      carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
               | (prop[2] & prop[1] & prop[0] & c_i);
      carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
               | (prop[3] & prop[2] & prop[1] & gen[0])
               | (prop[3] & prop[2] & prop[1] & prop[0] & c_i);
      sum_o    = prop ^ carry[3:0];
      cout_o   = carry[4];
      g_o      = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
               | (prop[3] & prop[2] & prop[1] & gen[0]);
      p_o      = &prop;
   end

endmodule

// File: rtl/cla_seq_add_ctrl.sv
// ---------------------------------------------------------------------------
// cla_seq_add_ctrl
// Multi-cycle WIDTH-bit adder that reuses a single cla_4bit slice, one nibble
// per cycle from the LSB end, holding the inter-nibble carry in a register.
// Optional feature macro: CLA_SUB_EN adds sub_in for a - b.
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   start_valid/start_ready : operand handshake (accepted only in IDLE)
//   a_in, b_in, cin_in      : operands and carry-in
//   sub_in                  : subtract request (CLA_SUB_EN builds only)
//   res_valid/res_ready     : result handshake
//   sum_out, cout_out       : sum and carry-out of bit WIDTH-1
//   ovf_out                 : two's-complement overflow
//   busy                    : high while an operation is in RUN or DONE
// ---------------------------------------------------------------------------
module cla_seq_add_ctrl
   import cla_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
`ifdef CLA_SUB_EN
   input  logic             sub_in,
`endif
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out,
   output logic             ovf_out,
   output logic             busy
);

   localparam int NSLICE = WIDTH / NIBBLE;
   localparam int IDXW   = clog2(NSLICE);
   localparam int SHIFTW = clog2(NIBBLE);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

   state_e                 state_q;
   logic [IDXW-1:0]        idx_q;
   logic [WIDTH-1:0]       a_q;
   logic [WIDTH-1:0]       b_q;
   logic [WIDTH-1:0]       sum_q;
   logic                   carry_q;
   logic                   resValid_q;
   logic                   busy_q;
   logic                   startReady_q;

   logic [WIDTH-1:0]       bEff_d;
   logic                   carryIn_d;
   logic [IDXW+SHIFTW-1:0] nibBase;
   logic [NIBBLE-1:0]      sliceSum;
   logic                   sliceCout;
   logic                   slice_g_unused;
   logic                   slice_p_unused;

   // Operand B and the initial carry as they are latched at accept time.
   // Subtraction is a + ~b + 1, so the caller's carry-in is overridden.
   always_comb begin
      bEff_d    = b_in;
      carryIn_d = cin_in;
`ifdef CLA_SUB_EN
      if (sub_in) begin
         bEff_d    = ~b_in;
         carryIn_d = 1'b1;
      end
`endif
   end

   // Bit offset of the nibble being processed this cycle
   assign nibBase = {idx_q, {SHIFTW{1'b0}}};

   cla_4bit uSlice (
      .a_i    (a_q[nibBase +: NIBBLE]),
      .b_i    (b_q[nibBase +: NIBBLE]),
      .c_i    (carry_q),
      .sum_o  (sliceSum),
      .cout_o (sliceCout),
      .g_o    (slice_g_unused),
      .p_o    (slice_p_unused)
   );

   // Controller FSM. IDLE latches operands, RUN walks the nibbles LSB first
   // feeding each slice carry-out into the next pass, DONE holds the result
   // until the consumer takes it. start_ready is low outside IDLE so a new
   // operation can never be accepted in the same cycle one completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         sum_q        <= '0;
         carry_q      <= 1'b0;
         resValid_q   <= 1'b0;
         busy_q       <= 1'b0;
         startReady_q <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_valid && startReady_q) begin
                  a_q          <= a_in;
                  b_q          <= bEff_d;
                  carry_q      <= carryIn_d;
                  idx_q        <= '0;
                  busy_q       <= 1'b1;
                  startReady_q <= 1'b0;
                  state_q      <= S_RUN;
               end
            end
            S_RUN: begin
               sum_q[nibBase +: NIBBLE] <= sliceSum;
               carry_q                  <= sliceCout;
               if (idx_q == LAST_IDX) begin
                  idx_q      <= '0;
                  resValid_q <= 1'b1;
                  state_q    <= S_DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  resValid_q   <= 1'b0;
                  busy_q       <= 1'b0;
                  startReady_q <= 1'b1;
                  state_q      <= S_IDLE;
               end
            end
            default: begin
               idx_q        <= '0;
               resValid_q   <= 1'b0;
               busy_q       <= 1'b0;
               startReady_q <= 1'b1;
               state_q      <= S_IDLE;
            end
         endcase
      end
   end

   // Result outputs read as zero unless a completed result is on offer, so
   // the nibbles being filled in during RUN are never visible.
   assign start_ready = startReady_q;
   assign res_valid   = resValid_q;
   assign busy        = busy_q;
   assign sum_out     = resValid_q ? sum_q : '0;
   assign cout_out    = resValid_q & carry_q;
   assign ovf_out     = resValid_q & (a_q[WIDTH-1] == b_q[WIDTH-1])
                      & (sum_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule
